// File: rtl/ratio_error_divider_pkg.sv
// rtl/ratio_error_divider_pkg.sv - shared state encoding and saturation bounds for the ratio error divider
package ratio_error_divider_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_DIVIDE,
    ST_FINISH,
    ST_OUTPUT
  } state_e;

  // Signed range of a w-bit two's complement word (w <= 31).
  function automatic int sat_max(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int sat_min(input int w);
    return -(1 << (w - 1));
  endfunction

endpackage

// File: rtl/ratio_error_divider_div.sv
// rtl/ratio_error_divider_div.sv - start/busy unsigned restoring divider, one quotient bit per clock, MSB first
module seq_restoring_div #(
  parameter int DATA_WIDTH = 24,
  parameter int Q_BITS     = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [Q_BITS-1:0]     quotient,
  output logic                  busy,
  output logic                  last
);

  localparam int CNT_W = $clog2(Q_BITS + 1);

  logic [DATA_WIDTH:0] rem_q, rem_d;
  logic [Q_BITS-1:0]   q_q, q_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_WIDTH:0] t;

  always_comb begin
    rem_d = rem_q;
    q_d   = q_q;
    cnt_d = cnt_q;
    // rem < divisor always holds here, so the shifted value never needs a wider register.
    t     = rem_q << 1;
    if (start) begin
      rem_d = {1'b0, dividend};
      q_d   = '0;
      cnt_d = CNT_W'(Q_BITS);
    end else if (cnt_q != '0) begin
      if (t >= {1'b0, divisor}) begin
        rem_d = t - {1'b0, divisor};
        q_d   = {q_q[Q_BITS-2:0], 1'b1};
      end else begin
        rem_d = t;
        q_d   = {q_q[Q_BITS-2:0], 1'b0};
      end
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q <= '0;
      q_q   <= '0;
      cnt_q <= '0;
    end else begin
      rem_q <= rem_d;
      q_q   <= q_d;
      cnt_q <= cnt_d;
    end
  end

  assign quotient = q_q;
  assign busy     = (cnt_q != '0);
  assign last     = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/ratio_error_divider.sv
// rtl/ratio_error_divider.sv - tau_A/tau_B fixed-point ratio minus setpoint, saturated onto an AXIS error stream
module ratio_error_divider
  import ratio_error_divider_pkg::*;
#(
  parameter int DATA_WIDTH = 24,
  parameter int FRAC_BITS  = 14,
  parameter int OUT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_sm_cycle_tdata,
  input  logic                  s_axis_sm_cycle_tvalid,
  input  logic [DATA_WIDTH-1:0] s_axis_Mm_cycle_tdata,
  input  logic                  s_axis_Mm_cycle_tvalid,
  input  logic [FRAC_BITS-1:0]  setpoint,
  output logic [OUT_WIDTH-1:0]  m_axis_err_tdata,
  output logic                  m_axis_err_tvalid,
  input  logic                  m_axis_err_tready,
  output logic [FRAC_BITS-1:0]  ratio,
  output logic                  overrange,
  output logic                  div_zero
);

  localparam logic signed [31:0] SAT_MAX = 32'(sat_max(OUT_WIDTH));
  localparam logic signed [31:0] SAT_MIN = 32'(sat_min(OUT_WIDTH));

  state_e                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  s_r_q, s_r_d, m_r_q, m_r_d;
  logic [DATA_WIDTH-1:0]  last_s_q, last_s_d, last_m_q, last_m_d;
  logic [FRAC_BITS-1:0]   setpoint_q, setpoint_d;
  logic [FRAC_BITS-1:0]   ratio_q, ratio_d;
  logic [OUT_WIDTH-1:0]   tdata_q, tdata_d;
  logic                   tvalid_q, tvalid_d;
  logic                   overrange_q, overrange_d;
  logic                   div_zero_q, div_zero_d;

  logic                   div_start, div_busy, div_last;
  logic [FRAC_BITS-1:0]   div_quotient;
  logic [FRAC_BITS-1:0]   q_val;
  logic signed [FRAC_BITS:0] e;
  logic signed [31:0]     e_wide;

  seq_restoring_div #(
    .DATA_WIDTH (DATA_WIDTH),
    .Q_BITS     (FRAC_BITS)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (s_r_q),
    .divisor  (m_r_q),
    .quotient (div_quotient),
    .busy     (div_busy),
    .last     (div_last)
  );

  always_comb begin
    state_d     = state_q;
    s_r_d       = s_r_q;
    m_r_d       = m_r_q;
    last_s_d    = last_s_q;
    last_m_d    = last_m_q;
    setpoint_d  = setpoint_q;
    ratio_d     = ratio_q;
    tdata_d     = tdata_q;
    tvalid_d    = tvalid_q;
    overrange_d = overrange_q;
    div_zero_d  = div_zero_q;
    div_start   = 1'b0;
    q_val       = overrange_q ? '1 : div_quotient;
    e           = $signed({1'b0, q_val} - {1'b0, setpoint_q});
    e_wide      = 32'(e);

    case (state_q)
      ST_IDLE: begin
        // Upstream valids are tied high, so only a changed pair counts as new work.
        if (s_axis_sm_cycle_tvalid && s_axis_Mm_cycle_tvalid &&
            ({s_axis_sm_cycle_tdata, s_axis_Mm_cycle_tdata} != {last_s_q, last_m_q})) begin
          s_r_d    = s_axis_sm_cycle_tdata;
          m_r_d    = s_axis_Mm_cycle_tdata;
          last_s_d = s_axis_sm_cycle_tdata;
          last_m_d = s_axis_Mm_cycle_tdata;
          state_d  = ST_CHECK;
        end
      end
      ST_CHECK: begin
        setpoint_d = setpoint;
        if (m_r_q == '0) begin
          div_zero_d = 1'b1;
          state_d    = ST_IDLE;
        end else if (s_r_q >= m_r_q) begin
          div_zero_d  = 1'b0;
          overrange_d = 1'b1;
          state_d     = ST_FINISH;
        end else begin
          div_zero_d  = 1'b0;
          overrange_d = 1'b0;
          div_start   = 1'b1;
          state_d     = ST_DIVIDE;
        end
      end
      ST_DIVIDE: begin
        if (div_busy && div_last) state_d = ST_FINISH;
      end
      ST_FINISH: begin
        if (e_wide > SAT_MAX)      tdata_d = SAT_MAX[OUT_WIDTH-1:0];
        else if (e_wide < SAT_MIN) tdata_d = SAT_MIN[OUT_WIDTH-1:0];
        else                       tdata_d = e_wide[OUT_WIDTH-1:0];
        ratio_d  = q_val;
        tvalid_d = 1'b1;
        state_d  = ST_OUTPUT;
      end
      ST_OUTPUT: begin
        if (m_axis_err_tready) begin
          tvalid_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      s_r_q       <= '0;
      m_r_q       <= '0;
      last_s_q    <= '0;
      last_m_q    <= '0;
      setpoint_q  <= '0;
      ratio_q     <= '0;
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      overrange_q <= 1'b0;
      div_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_r_q       <= s_r_d;
      m_r_q       <= m_r_d;
      last_s_q    <= last_s_d;
      last_m_q    <= last_m_d;
      setpoint_q  <= setpoint_d;
      ratio_q     <= ratio_d;
      tdata_q     <= tdata_d;
      tvalid_q    <= tvalid_d;
      overrange_q <= overrange_d;
      div_zero_q  <= div_zero_d;
    end
  end

  assign m_axis_err_tdata  = tdata_q;
  assign m_axis_err_tvalid = tvalid_q;
  assign ratio             = ratio_q;
  assign overrange         = overrange_q;
  assign div_zero          = div_zero_q;

endmodule

// File: tb/tb_ratio_error_divider.sv
// tb/tb_ratio_error_divider.sv - directed and randomized checks of ratio_error_divider against an arithmetic model
module tb_ratio_error_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] sm, mm;
  logic        sm_valid, mm_valid;
  logic [13:0] setpoint;
  logic [15:0] tdata;
  logic        tvalid;
  logic        tready;
  logic [13:0] ratio;
  logic        overrange;
  logic        div_zero;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ratio_error_divider dut (
    .clk                    (clk),
    .rst                    (rst),
    .s_axis_sm_cycle_tdata  (sm),
    .s_axis_sm_cycle_tvalid (sm_valid),
    .s_axis_Mm_cycle_tdata  (mm),
    .s_axis_Mm_cycle_tvalid (mm_valid),
    .setpoint               (setpoint),
    .m_axis_err_tdata       (tdata),
    .m_axis_err_tvalid      (tvalid),
    .m_axis_err_tready      (tready),
    .ratio                  (ratio),
    .overrange              (overrange),
    .div_zero               (div_zero)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint model_q(input longint s, input longint m);
    if (s >= m) return 16383;
    return (s * 16384) / m;
  endfunction

  function automatic logic [15:0] model_err(input longint q, input longint sp);
    longint e;
    e = q - sp;
    if (e > 32767) e = 32767;
    if (e < -32768) e = -32768;
    return 16'(e);
  endfunction

  task automatic wait_valid(output int edges, input int budget);
    edges = 0;
    while (edges < budget) begin
      @(posedge clk); #1;
      edges++;
      if (tvalid) break;
    end
  endtask

  task automatic accept();
    tready = 1'b1;
    @(posedge clk); #1;
    chk("accept_drops_tvalid", 64'(tvalid), 64'd0);
    tready = 1'b0;
  endtask

  task automatic run_pair(input string tag, input int s, input int m, input int sp);
    int lat;
    longint q;
    sm = 24'(s); mm = 24'(m); setpoint = 14'(sp);
    wait_valid(lat, 40);
    q = model_q(s, m);
    chk({tag, "_latency"}, 64'(lat), (s >= m) ? 64'd3 : 64'd17);
    chk({tag, "_ratio"}, 64'(ratio), 64'(q));
    chk({tag, "_err"}, 64'(tdata), 64'(model_err(q, sp)));
    chk({tag, "_overrange"}, 64'(overrange), (s >= m) ? 64'd1 : 64'd0);
    chk({tag, "_div_zero"}, 64'(div_zero), 64'd0);
    accept();
  endtask

  initial begin
    int lat;
    int cnt;
    int s, m;

    rst = 1'b1; sm = '0; mm = '0; sm_valid = 1'b1; mm_valid = 1'b1;
    setpoint = '0; tready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {tdata, 14'(ratio), 3'(tvalid), 3'(overrange), 3'(div_zero)}, '0);
    rst = 1'b0;

    repeat (10) @(posedge clk);
    #1;
    chk("zero_pair_no_start", 64'(tvalid), 64'd0);

    run_pair("basic", 1000, 4000, 8192);
    run_pair("over", 5000, 4000, 8192);

    sm = 24'd100; mm = 24'd0;
    cnt = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (tvalid) cnt++;
    end
    chk("divzero_no_tvalid", 64'(cnt), 64'd0);
    chk("divzero_flag", 64'(div_zero), 64'd1);
    chk("divzero_keeps_overrange", 64'(overrange), 64'd1);
    run_pair("after_divzero", 100, 300, 0);

    // Inputs change while the divider is busy; only the newest pair survives.
    sm = 24'd1000; mm = 24'd4000; setpoint = 14'd8192;
    repeat (4) @(posedge clk);
    #1 sm = 24'd2000;
    repeat (4) @(posedge clk);
    #1 sm = 24'd3000;
    wait_valid(lat, 40);
    chk("busy_first_latency", 64'(lat), 64'd9);
    chk("busy_first_err", 64'(tdata), 64'hF000);
    cnt = 0;
    repeat (50) begin
      @(posedge clk); #1;
      if (!tvalid || tdata !== 16'hF000) cnt++;
    end
    chk("hold_stable", 64'(cnt), 64'd0);
    accept();
    wait_valid(lat, 40);
    chk("newest_latency", 64'(lat), 64'd17);
    chk("newest_ratio", 64'(ratio), 64'd12288);
    chk("newest_err", 64'(tdata), 64'(model_err(12288, 8192)));
    accept();

    run_pair("reuse", 1000, 4000, 8192);
    tready = 1'b1;
    cnt = 0;
    repeat (200) begin
      @(posedge clk); #1;
      if (tvalid) cnt++;
    end
    chk("no_repeat_beats", 64'(cnt), 64'd0);
    tready = 1'b0;

    sm = 24'd7000; mm = 24'd9000;
    repeat (5) @(posedge clk);
    #1;
    sm = 24'd1000; mm = 24'd4000;
    rst = 1'b1;
    #1;
    chk("midreset_outputs", {tdata, 14'(ratio), 3'(tvalid), 3'(overrange), 3'(div_zero)}, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    wait_valid(lat, 40);
    chk("post_reset_latency", 64'(lat), 64'd17);
    chk("post_reset_err", 64'(tdata), 64'hF000);
    accept();

    for (int i = 0; i < 12; i++) begin
      m = int'($urandom_range(1, 24'hFFFFFF));
      if ($urandom_range(0, 3) != 0) s = int'($urandom_range(0, m - 1));
      else s = int'($urandom_range(m, 24'hFFFFFF));
      if (s == 1000 && m == 4000) s = 999;
      run_pair($sformatf("rand%0d", i), s, m, int'($urandom_range(0, 16383)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
